// File: rtl/cakegame_pkg.sv
// Shared definitions for the cake game player-input path: debug state encodings and
// default sizing.
package cakegame_pkg;

  localparam int unsigned N_BUTTONS_DEF       = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 50000;

  typedef enum logic [1:0] {
    DB_IDLE     = 2'd0,
    DB_DEBOUNCE = 2'd1,
    DB_PRESSED  = 2'd2,
    DB_RELEASE  = 2'd3
  } db_state_e;

endpackage

// File: rtl/cakegame_sync.sv
// Two-flop synchroniser for asynchronous level inputs, cleared by a synchronous reset.
module cakegame_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cakegame_play_input.sv
// Player-input stage: synchronises and debounces the buttons and emits one has_play pulse
// per accepted press, holding the pressed pattern on play.
module cakegame_play_input
  import cakegame_pkg::*;
#(
  parameter int unsigned N_BUTTONS       = N_BUTTONS_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [N_BUTTONS-1:0] buttons,
  output logic                 has_play,
  output logic [N_BUTTONS-1:0] play,
  output logic                 invalid,
  output logic [1:0]           db_state
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  db_state_e            state;
  logic [CW-1:0]        cnt;
  logic                 armed;
  logic [N_BUTTONS-1:0] sample;
  logic [N_BUTTONS-1:0] sb;
  logic [1:0]           sync_vld;

  cakegame_sync #(
    .WIDTH (N_BUTTONS)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (buttons),
    .q     (sb)
  );

  // The synchroniser flushes zeros for two cycles after reset; those are not a real
  // release, so a button held through reset must not arm the stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_vld <= 2'b00;
    end else begin
      sync_vld <= {sync_vld[0], 1'b1};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= DB_IDLE;
      cnt      <= '0;
      armed    <= 1'b0;
      sample   <= '0;
      play     <= '0;
      has_play <= 1'b0;
      invalid  <= 1'b0;
    end else begin
      has_play <= 1'b0;
      invalid  <= 1'b0;
      unique case (state)
        DB_IDLE: begin
          if (armed && enable && (sb != '0)) begin
            state  <= DB_DEBOUNCE;
            sample <= sb;
            cnt    <= '0;
            armed  <= 1'b0;
          end else if ((sb == '0) && sync_vld[1]) begin
            armed <= 1'b1;
          end else if (!enable) begin
            // A button pressed while disabled stays ignored until it is released.
            armed <= 1'b0;
          end
        end
        DB_DEBOUNCE: begin
          if (!enable || (sb != sample)) begin
            state <= DB_IDLE;
          end else if (cnt == CNT_LAST) begin
            state    <= DB_PRESSED;
            has_play <= 1'b1;
            play     <= sample;
            invalid  <= (sample & (sample - N_BUTTONS'(1))) != '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DB_PRESSED: begin
          state <= DB_RELEASE;
          cnt   <= '0;
        end
        DB_RELEASE: begin
          if (sb != '0) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= DB_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

  assign db_state = state;

endmodule

// File: tb/tb_cakegame_play_input.sv
// Scoreboard bench for cakegame_play_input with a timestamp-based reference model.
module tb_cakegame_play_input;

  localparam int unsigned NB = 4;
  localparam int unsigned D  = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [NB-1:0] buttons = '0;
  logic          has_play;
  logic [NB-1:0] play;
  logic          invalid;
  logic [1:0]    db_state;

  cakegame_play_input #(
    .N_BUTTONS       (NB),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .buttons  (buttons),
    .has_play (has_play),
    .play     (play),
    .invalid  (invalid),
    .db_state (db_state)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            cyc;
    logic [NB-1:0] play;
    logic          inv;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: raw button history with validity, plus timestamps of phases.
  logic [NB-1:0] r1 = '0, r2 = '0;
  bit            v1 = 0, v2 = 0;
  bit            m_armed = 0, cand_on = 0, rel_on = 0, pulse_now = 0;
  logic [NB-1:0] cand = '0, m_play = '0;
  int            start = 0, anchor = 0;
  logic [NB-1:0] next_play = '0, cur_play = '0;
  logic [1:0]    next_state = 2'd0, cur_state = 2'd0;

  int            pulses_seen = 0;
  int            last_pulse_cyc = 0;
  logic [NB-1:0] last_play = '0;
  logic          last_inv = 1'b0;

  task automatic model_step(input logic r, input logic e, input logic [NB-1:0] b);
    int            k;
    logic [NB-1:0] s;
    bit            sv;
    bit            pulse_next;
    k          = cyc;
    s          = r2;
    sv         = v2;
    pulse_next = 0;
    cur_play   = next_play;
    cur_state  = next_state;
    if (r) begin
      m_armed = 0; cand_on = 0; rel_on = 0; m_play = '0;
      r1 = '0; r2 = '0; v1 = 0; v2 = 0;
    end else begin
      if (pulse_now) begin
        rel_on = 1;
        anchor = k + 1;
      end else if (rel_on) begin
        if (s != '0) anchor = k + 1;
        else if (k - anchor + 1 >= int'(D)) rel_on = 0;
      end else if (cand_on) begin
        if (!e || s != cand) begin
          cand_on = 0;
        end else if (k - start == int'(D) - 1) begin
          cand_on    = 0;
          pulse_next = 1;
          m_play     = cand;
          exp_q.push_back('{cyc: k + 1, play: cand, inv: ($countones(cand) > 1)});
        end
      end else begin
        if (m_armed && e && s != '0) begin
          cand_on = 1; cand = s; start = k + 1; m_armed = 0;
        end else if (s == '0 && sv) begin
          m_armed = 1;
        end else if (!e) begin
          m_armed = 0;
        end
      end
      r2 = r1; v2 = v1;
      r1 = b;  v1 = 1;
    end
    pulse_now  = pulse_next;
    next_play  = m_play;
    next_state = pulse_now ? 2'd2 : rel_on ? 2'd3 : cand_on ? 2'd1 : 2'd0;
  endtask

  task automatic tick(input logic r, input logic e, input logic [NB-1:0] b);
    @(posedge clock);
    #1;
    reset   = r;
    enable  = e;
    buttons = b;
    model_step(r, e, b);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (cyc >= 1) begin
      checks++;
      if (play !== cur_play) begin
        errors++;
        $display("FAIL play cyc=%0d got %b want %b", cyc, play, cur_play);
      end
      checks++;
      if (db_state !== cur_state) begin
        errors++;
        $display("FAIL db_state cyc=%0d got %0d want %0d", cyc, db_state, cur_state);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_pulse cyc=%0d want pulse at %0d", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      checks++;
      if (has_play === 1'b1) begin
        pulses_seen++;
        last_pulse_cyc = cyc;
        last_play      = play;
        last_inv       = invalid;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse cyc=%0d play=%b", cyc, play);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.play !== play || e.inv !== invalid) begin
            errors++;
            $display("FAIL pulse cyc=%0d got play=%b inv=%b want cyc=%0d play=%b inv=%b",
                     cyc, play, invalid, e.cyc, e.play, e.inv);
          end
        end
      end else if (has_play !== 1'b0 || invalid !== 1'b0) begin
        errors++;
        $display("FAIL idle_outputs cyc=%0d has_play=%b invalid=%b want 0 0",
                 cyc, has_play, invalid);
      end
    end
  end

  initial begin
    int p0;
    int r;
    logic [NB-1:0] b;
    int len;
    logic en;
    logic rs;

    repeat (3) tick(1, 0, '0);
    repeat (6) tick(0, 1, '0);

    // Single clean press.
    p0 = pulses_seen;
    tick(0, 1, 4'b0100);
    r = cyc;
    repeat (19) tick(0, 1, 4'b0100);
    chk("t1_pulses", pulses_seen - p0, 1);
    chk("t1_latency", last_pulse_cyc, r + 7);
    chk("t1_play", int'(last_play), 4);
    chk("t1_invalid", int'(last_inv), 0);
    repeat (10) tick(0, 1, '0);

    // Bounce, then a stable hold.
    p0 = pulses_seen;
    for (int i = 0; i < 4; i++) begin
      repeat (2) tick(0, 1, 4'b0100);
      repeat (2) tick(0, 1, 4'b0000);
    end
    chk("t2_bounce_no_pulse", pulses_seen - p0, 0);
    tick(0, 1, 4'b0100);
    r = cyc;
    repeat (14) tick(0, 1, 4'b0100);
    chk("t2_pulses", pulses_seen - p0, 1);
    chk("t2_latency", last_pulse_cyc, r + 7);
    repeat (10) tick(0, 1, '0);

    // Held while disabled, then enabled: ignored until released.
    p0 = pulses_seen;
    repeat (6) tick(0, 0, 4'b0010);
    repeat (10) tick(0, 1, 4'b0010);
    chk("t3_held_no_pulse", pulses_seen - p0, 0);
    repeat (5) tick(0, 1, '0);
    repeat (10) tick(0, 1, 4'b0001);
    chk("t3_pulses", pulses_seen - p0, 1);
    chk("t3_play", int'(play), 1);
    repeat (10) tick(0, 1, '0);

    // Two buttons at once.
    p0 = pulses_seen;
    repeat (10) tick(0, 1, 4'b0011);
    chk("t4_pulses", pulses_seen - p0, 1);
    chk("t4_play", int'(last_play), 3);
    chk("t4_invalid", int'(last_inv), 1);
    repeat (10) tick(0, 1, '0);

    // enable drops in the PRESSED cycle.
    p0 = pulses_seen;
    repeat (7) tick(0, 1, 4'b0100);
    repeat (6) tick(0, 0, 4'b0100);
    chk("en_drop_pulses", pulses_seen - p0, 1);
    repeat (10) tick(0, 1, '0);

    // Reset during DEBOUNCE with cnt=2, button kept held.
    p0 = pulses_seen;
    repeat (5) tick(0, 1, 4'b1000);
    tick(1, 1, 4'b1000);
    tick(0, 1, 4'b1000);
    @(negedge clock);
    chk("t5_state_after_reset", int'(db_state), 0);
    chk("t5_play_after_reset", int'(play), 0);
    repeat (12) tick(0, 1, 4'b1000);
    chk("t5_held_no_pulse", pulses_seen - p0, 0);
    repeat (6) tick(0, 1, '0);
    repeat (10) tick(0, 1, 4'b1000);
    chk("t5_repress", pulses_seen - p0, 1);
    repeat (10) tick(0, 1, '0);

    // Short release glitch is not a new press.
    p0 = pulses_seen;
    repeat (10) tick(0, 1, 4'b0001);
    repeat (2) tick(0, 1, '0);
    repeat (10) tick(0, 1, 4'b0001);
    chk("t6_glitch", pulses_seen - p0, 1);
    repeat (10) tick(0, 1, '0);
    repeat (10) tick(0, 1, 4'b0001);
    chk("t6_repress", pulses_seen - p0, 2);
    repeat (10) tick(0, 1, '0);

    // Randomised traffic against the model.
    for (int s = 0; s < 300; s++) begin
      case ($urandom_range(0, 3))
        0, 1:    b = '0;
        2:       b = NB'(1) << $urandom_range(0, NB - 1);
        default: b = NB'($urandom_range(1, 15));
      endcase
      en  = ($urandom_range(0, 99) < 85);
      rs  = ($urandom_range(0, 99) < 3);
      len = $urandom_range(1, 12);
      if (rs) tick(1, en, b);
      repeat (len) tick(0, en, b);
    end

    repeat (20) tick(0, 1, '0);
    @(negedge clock);
    chk("pending_pulses", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
